// File: rtl/ser_shift_ctrl_if.sv
// Bundle for the serial shift controller: frame request and parallel byte in,
// serial line, shift strobe and frame status out.
interface ser_shift_ctrl_if;
  logic       START;
  logic [7:0] DIN;
  logic       SI;
  logic       SO;
  logic       SH;
  logic       BUSY;
  logic       DONE;
  logic [7:0] DOUT;

  modport master (
    output START, DIN, SI,
    input  SO, SH, BUSY, DONE, DOUT
  );

  modport slave (
    input  START, DIN, SI,
    output SO, SH, BUSY, DONE, DOUT
  );
endinterface

// File: rtl/ser_shift_ctrl.sv
// Full-duplex 8-bit serial shifter: transmits a captured byte MSB first while
// sampling SI, one bit every DIV clocks, and reports the received byte.
module ser_shift_ctrl #(
  parameter int DIV = 4
) (
  input  logic         C,
  input  logic         CLR,
  ser_shift_ctrl_if.slave bus
);

  localparam int              DW       = $clog2(DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [2:0]      bit_reg,   bit_next;
  logic [DW-1:0]   div_reg,   div_next;
  logic [7:0]      tx_reg,    tx_next;
  logic [7:0]      rx_reg,    rx_next;
  logic [7:0]      dout_reg,  dout_next;
  logic            tick;

  // A tick is the last divider cycle of a bit slot; the shift happens on its edge.
  assign tick = (state_reg == ST_SHIFT) && (div_reg == DIV_LAST);

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_reg <= ST_IDLE;
      bit_reg   <= '0;
      div_reg   <= '0;
      tx_reg    <= '0;
      rx_reg    <= '0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      bit_reg   <= bit_next;
      div_reg   <= div_next;
      tx_reg    <= tx_next;
      rx_reg    <= rx_next;
      dout_reg  <= dout_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bit_next   = bit_reg;
    div_next   = div_reg;
    tx_next    = tx_reg;
    rx_next    = rx_reg;
    dout_next  = dout_reg;

    case (state_reg)
      ST_IDLE: begin
        if (bus.START) begin
          tx_next    = bus.DIN;
          bit_next   = '0;
          div_next   = '0;
          state_next = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        div_next = tick ? '0 : div_reg + 1'b1;
        if (tick) begin
          rx_next  = {rx_reg[6:0], bus.SI};
          tx_next  = {tx_reg[6:0], 1'b0};
          bit_next = bit_reg + 1'b1;
          // The eighth bit is taken straight from SI so DOUT holds the whole byte.
          if (bit_reg == 3'd7) begin
            dout_next  = {rx_reg[6:0], bus.SI};
            state_next = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.SO   = tx_reg[7];
  assign bus.SH   = tick;
  assign bus.BUSY = (state_reg != ST_IDLE);
  assign bus.DONE = (state_reg == ST_DONE);
  assign bus.DOUT = dout_reg;

endmodule

// File: doc/ser_shift_ctrl.md
SER_SHIFT_CTRL -- requirements
Module: ser_shift_ctrl

Interface
REQ-001 Parameter: DIV, default 4, clock cycles per shift tick; legal range 2..256.
REQ-002 Port: C  input  1  system clock, all state updates on rising edge.
REQ-003 Port: CLR  input  1  reset, asynchronous, active-high.
REQ-004 Port: START  input  1  frame request, sampled on rising edge of C.
REQ-005 Port: DIN  input  8  parallel transmit byte, captured when START is accepted.
REQ-006 Port: SI  input  1  serial receive data.
REQ-007 Port: SO  output  1  serial transmit data, MSB first.
REQ-008 Port: SH  output  1  shift strobe for an external shift register, high one cycle per bit.
REQ-009 Port: BUSY  output  1  high while a frame is in progress.
REQ-010 Port: DONE  output  1  one-cycle pulse marking frame completion.
REQ-011 Port: DOUT  output  8  last fully received byte.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and DONE, plus a 3-bit bit counter, a divider counter (0..DIV-1), an 8-bit tx shift register and an 8-bit rx shift register.
REQ-013 In IDLE, START=1 at edge k SHALL load tx<=DIN, clear the bit and divider counters, and enter SHIFT; START=0 SHALL keep the FSM in IDLE.
REQ-014 START SHALL be ignored in SHIFT and DONE; there is no queueing of requests.
REQ-015 SO SHALL equal tx[7] at all times, so DIN[7] appears on SO in the cycle after edge k.
REQ-016 In SHIFT, the divider SHALL increment every cycle and wrap from DIV-1 to 0.
REQ-017 SH SHALL be high exactly in the SHIFT cycles where divider==DIV-1, and low in all other states.
REQ-018 Each edge with SH=1 (a tick) SHALL do three things: rx<={rx[6:0],SI}, tx<={tx[6:0],1'b0}, and bit counter +1.
REQ-019 Ticks SHALL occur at edges k+DIV*i for i=1..8.
REQ-020 On the 8th tick (bit counter==7), the FSM SHALL enter DONE and DOUT SHALL load {rx[6:0],SI}, which includes the 8th bit.
REQ-021 DONE state SHALL last exactly one cycle with DONE=1 and then return to IDLE.
REQ-022 BUSY SHALL be 1 in SHIFT and DONE and 0 in IDLE, so BUSY is high for 8*DIV+1 cycles per frame.
REQ-023 The earliest next START acceptance SHALL be at edge k+8*DIV+2.
REQ-024 DOUT SHALL hold its value between frames and change only on the DONE transition.
REQ-025 The bit counter SHALL wrap 7->0 only together with the transition to DONE; no partial frames are ever reported.

Reset
REQ-026 While CLR=1, all outputs SHALL be forced immediately, independent of C: state=IDLE, tx=0, rx=0, counters=0, DOUT=8'h00, SO=0, SH=0, BUSY=0, DONE=0.
REQ-027 CLR asserted mid-frame SHALL abort the frame with no DONE pulse, and DOUT SHALL be 8'h00.
REQ-028 After CLR is released, the first START SHALL behave as in REQ-013 on the next rising edge.

Verification (DIV=4)
REQ-029 Loopback (SI=SO), DIN=8'hA5, START for one cycle at edge k -> SO bit sequence 1,0,1,0,0,1,0,1; SH pulses at edges k+4..k+32; DONE=1 in cycle after edge k+32; DOUT=8'hA5; BUSY low after edge k+33.
REQ-030 SI tied 1, DIN=8'h00 -> SO=0 throughout the frame, DOUT=8'hFF, exactly 8 SH pulses, exactly 1 DONE pulse.
REQ-031 START held high continuously with DIN=8'h3C -> frames accepted at edges k, k+34, k+68; each frame transmits 8'h3C; DIN changes while BUSY have no effect on the frame in progress.
REQ-032 START pulsed at edges k+5 and k+32 during a frame -> ignored; frame completes normally; BUSY falls after edge k+33.
REQ-033 CLR asserted asynchronously between edges k+12 and k+13 -> BUSY, SH, SO and DOUT drop to 0 without waiting for an edge; no DONE pulse; a new START after CLR release yields a correct full frame.
REQ-034 DIV=2 loopback with DIN=8'h81 -> DONE in cycle after edge k+16, DOUT=8'h81.
